// File: rtl/jump_target_unit.sv
// rtl/jump_target_unit.sv - next-PC target generator with return-address stack
module jump_target_unit #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        mode,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] link_addr,
  output logic              out_valid,
  output logic              ras_miss,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    MODE_NONE = 3'b000,
    MODE_J    = 3'b001,
    MODE_JAL  = 3'b010,
    MODE_JR   = 3'b011,
    MODE_BR   = 3'b100,
    MODE_RET  = 3'b101
  } mode_t;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [CNT_W-1:0]  count;

  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] target_c;
  logic [ADDR_W-1:0] link_c;
  logic              push_c;
  logic              pop_c;
  logic              miss_c;

  // Opcode/function bits of the instruction are decoded upstream and not needed here.
  logic              unused_instr_hi;
  assign unused_instr_hi = ^instr[31:26];

  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_MAX);

  // Modular pointer steps so non-power-of-two depths wrap correctly.
  assign ptr_inc = (top == PTR_MAX) ? '0 : top + PTR_W'(1);
  assign ptr_dec = (top == '0) ? PTR_MAX : top - PTR_W'(1);

  // Region jump keeps the top PC bits; branch offset is a sign-extended word offset.
  assign jump_tgt = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
  assign br_off   = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};

  // Decode the mode into the next target, link value and stack action.
  always_comb begin
    target_c = pc_plus4;
    link_c   = '0;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    miss_c   = 1'b0;
    case (mode)
      MODE_J:   target_c = jump_tgt;
      MODE_JAL: begin
        target_c = jump_tgt;
        link_c   = pc_plus4;
        push_c   = 1'b1;
      end
      MODE_JR:  target_c = reg_target;
      MODE_BR:  target_c = pc_plus4 + br_off;
      MODE_RET: begin
        if (ras_empty) begin
          target_c = reg_target;
          miss_c   = 1'b1;
        end else begin
          target_c = ras_mem[top];
          pop_c    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Register outputs and update stack pointer/count; reset drops any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      target       <= '0;
      link_addr    <= '0;
      out_valid    <= 1'b0;
      ras_miss     <= 1'b0;
      ras_overflow <= 1'b0;
      top          <= '0;
      count        <= '0;
    end else begin
      out_valid <= in_valid;
      ras_miss  <= in_valid & miss_c;
      if (in_valid) begin
        target    <= target_c;
        link_addr <= link_c;
        if (push_c) begin
          top <= ptr_inc;
          if (ras_full) begin
            ras_overflow <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end else if (pop_c) begin
          top   <= ptr_dec;
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Stack storage; a push while full lands on the oldest entry.
  always_ff @(posedge clk) begin
    if (!reset && in_valid && push_c) begin
      ras_mem[ptr_inc] <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_jump_target_unit.sv
// tb/tb_jump_target_unit.sv - directed self-checking bench for jump_target_unit
module tb_jump_target_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [2:0]  mode;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [31:0] reg_target;
  logic [31:0] target;
  logic [31:0] link_addr;
  logic        out_valid;
  logic        ras_miss;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;

  int n_cmp;
  int n_bad;

  jump_target_unit #(.ADDR_W(32), .RAS_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .mode         (mode),
    .instr        (instr),
    .pc_plus4     (pc_plus4),
    .reg_target   (reg_target),
    .target       (target),
    .link_addr    (link_addr),
    .out_valid    (out_valid),
    .ras_miss     (ras_miss),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request and advance past the capturing edge.
  task automatic req(input logic [2:0] m, input logic [31:0] ins,
                     input logic [31:0] pc, input logic [31:0] rt);
    in_valid   = 1'b1;
    mode       = m;
    instr      = ins;
    pc_plus4   = pc;
    reg_target = rt;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; mode = 3'b001; instr = 32'h0800_0010;
    pc_plus4 = 32'h4000_1000; reg_target = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    n_cmp++; if (target !== 32'h0) begin n_bad++; $display("FAIL reset_target got %h exp %h", target, 32'h0); end
    n_cmp++; if (link_addr !== 32'h0) begin n_bad++; $display("FAIL reset_link got %h exp %h", link_addr, 32'h0); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (ras_miss !== 1'b0) begin n_bad++; $display("FAIL reset_miss got %b exp 0", ras_miss); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b exp 1", ras_empty); end
    n_cmp++; if (ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b exp 0", ras_full); end
    n_cmp++; if (ras_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b exp 0", ras_overflow); end
  endtask

  task automatic test_jump();
    req(3'b001, 32'h0800_0010, 32'h4000_1000, 32'h0);
    n_cmp++; if (target !== 32'h4000_0040) begin n_bad++; $display("FAIL j_target got %h exp %h", target, 32'h4000_0040); end
    n_cmp++; if (link_addr !== 32'h0) begin n_bad++; $display("FAIL j_link got %h exp %h", link_addr, 32'h0); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL j_out_valid got %b exp 1", out_valid); end
    idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL j_pulse_end got %b exp 0", out_valid); end
  endtask

  task automatic test_branch();
    req(3'b100, 32'h1000_FFFC, 32'h0040_0010, 32'h0);
    n_cmp++; if (target !== 32'h0040_0000) begin n_bad++; $display("FAIL br_back got %h exp %h", target, 32'h0040_0000); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL br_back_valid got %b exp 1", out_valid); end
    req(3'b100, 32'h1000_FFFE, 32'h0000_0004, 32'h0);
    n_cmp++; if (target !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL br_wrap got %h exp %h", target, 32'hFFFF_FFFC); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL br_wrap_valid got %b exp 1", out_valid); end
    req(3'b100, 32'h1000_0010, 32'h0000_1000, 32'h0);
    n_cmp++; if (target !== 32'h0000_1040) begin n_bad++; $display("FAIL br_fwd got %h exp %h", target, 32'h0000_1040); end
    req(3'b000, 32'h0800_0010, 32'h0000_2004, 32'h5555_0000);
    n_cmp++; if (target !== 32'h0000_2004) begin n_bad++; $display("FAIL none_target got %h exp %h", target, 32'h0000_2004); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL none_valid got %b exp 1", out_valid); end
    req(3'b111, 32'h0800_0010, 32'h0000_3008, 32'h5555_0000);
    n_cmp++; if (target !== 32'h0000_3008) begin n_bad++; $display("FAIL mode7_target got %h exp %h", target, 32'h0000_3008); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL mode7_empty got %b exp 1", ras_empty); end
    idle();
  endtask

  task automatic test_jal_ret();
    req(3'b010, 32'h0C10_0040, 32'h0040_0008, 32'h0);
    n_cmp++; if (target !== 32'h0040_0100) begin n_bad++; $display("FAIL jal_target got %h exp %h", target, 32'h0040_0100); end
    n_cmp++; if (link_addr !== 32'h0040_0008) begin n_bad++; $display("FAIL jal_link got %h exp %h", link_addr, 32'h0040_0008); end
    n_cmp++; if (ras_empty !== 1'b0) begin n_bad++; $display("FAIL jal_empty got %b exp 0", ras_empty); end
    req(3'b101, 32'h0, 32'h0000_0000, 32'hDEAD_0000);
    n_cmp++; if (target !== 32'h0040_0008) begin n_bad++; $display("FAIL ret_target got %h exp %h", target, 32'h0040_0008); end
    n_cmp++; if (ras_miss !== 1'b0) begin n_bad++; $display("FAIL ret_miss got %b exp 0", ras_miss); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL ret_empty got %b exp 1", ras_empty); end
    n_cmp++; if (link_addr !== 32'h0) begin n_bad++; $display("FAIL ret_link got %h exp %h", link_addr, 32'h0); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_t [5];
    exp_t[0] = 32'h50; exp_t[1] = 32'h40; exp_t[2] = 32'h30; exp_t[3] = 32'h20; exp_t[4] = 32'h99;
    for (int i = 0; i < 5; i++) begin
      req(3'b010, 32'h0, 32'((i + 1) * 16), 32'h0);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL push%0d_valid got %b exp 1", i, out_valid); end
      n_cmp++; if (ras_full !== (i >= 3)) begin n_bad++; $display("FAIL push%0d_full got %b exp %b", i, ras_full, (i >= 3)); end
      n_cmp++; if (ras_overflow !== (i == 4)) begin n_bad++; $display("FAIL push%0d_overflow got %b exp %b", i, ras_overflow, (i == 4)); end
    end
    for (int i = 0; i < 5; i++) begin
      req(3'b101, 32'h0, 32'h0, 32'h99);
      n_cmp++; if (target !== exp_t[i]) begin n_bad++; $display("FAIL pop%0d_target got %h exp %h", i, target, exp_t[i]); end
      n_cmp++; if (ras_miss !== (i == 4)) begin n_bad++; $display("FAIL pop%0d_miss got %b exp %b", i, ras_miss, (i == 4)); end
      n_cmp++; if (ras_overflow !== 1'b1) begin n_bad++; $display("FAIL pop%0d_overflow got %b exp 1", i, ras_overflow); end
      n_cmp++; if (ras_empty !== (i >= 3)) begin n_bad++; $display("FAIL pop%0d_empty got %b exp %b", i, ras_empty, (i >= 3)); end
    end
    idle();
    n_cmp++; if (ras_miss !== 1'b0) begin n_bad++; $display("FAIL miss_pulse_end got %b exp 0", ras_miss); end
  endtask

  task automatic test_reset_mid();
    req(3'b010, 32'h0, 32'h0000_0100, 32'h0);
    req(3'b010, 32'h0, 32'h0000_0200, 32'h0);
    reset = 1'b1; in_valid = 1'b1; mode = 3'b101; reg_target = 32'h7777;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL rmid_empty got %b exp 1", ras_empty); end
    n_cmp++; if (ras_overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_overflow got %b exp 0", ras_overflow); end
    n_cmp++; if (target !== 32'h0) begin n_bad++; $display("FAIL rmid_target got %h exp %h", target, 32'h0); end
    req(3'b101, 32'h0, 32'h0, 32'h0000_1234);
    n_cmp++; if (target !== 32'h0000_1234) begin n_bad++; $display("FAIL rmid_ret_target got %h exp %h", target, 32'h0000_1234); end
    n_cmp++; if (ras_miss !== 1'b1) begin n_bad++; $display("FAIL rmid_ret_miss got %b exp 1", ras_miss); end
    idle();
  endtask

  task automatic test_idle_hold();
    req(3'b011, 32'h0, 32'h0000_4000, 32'hABCD_0000);
    n_cmp++; if (target !== 32'hABCD_0000) begin n_bad++; $display("FAIL jr_target got %h exp %h", target, 32'hABCD_0000); end
    for (int i = 0; i < 3; i++) begin
      mode = 3'b001; pc_plus4 = 32'hFFFF_0000; reg_target = 32'h1;
      idle();
      n_cmp++; if (target !== 32'hABCD_0000) begin n_bad++; $display("FAIL hold%0d_target got %h exp %h", i, target, 32'hABCD_0000); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold%0d_valid got %b exp 0", i, out_valid); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_jump();
    test_branch();
    test_jal_ret();
    test_back_to_back();
    test_reset_mid();
    test_idle_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jump_target_unit.md
Name: jump_target_unit

Overview:
- Parametrised next-PC target generator for the fetch/decode path.
- Computes J/JAL, JR, conditional-branch and return targets from the instruction word, PC+4 and a register operand, and registers the result with a one-cycle latency.
- Adds a return-address stack (RAS): JAL pushes its link address, RET pops it, with overflow and miss reporting.

Parameters:
- ADDR_W, 32, address/PC width; must be ≥ 29.
- RAS_DEPTH, 4, return-address stack entries; must be ≥ 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request qualifier; sampled every cycle.
- mode  input  3  000 NONE, 001 J, 010 JAL, 011 JR, 100 BR, 101 RET; 110/111 treated as NONE.
- instr  input  32  instruction word.
- pc_plus4  input  ADDR_W  PC of the current instruction plus 4.
- reg_target  input  ADDR_W  register-sourced target, used by JR and by RET on a RAS miss.
- target  output  ADDR_W  computed target, registered.
- link_addr  output  ADDR_W  link value for JAL, registered; 0 for all other modes.
- out_valid  output  1  one-cycle pulse marking target/link_addr valid.
- ras_miss  output  1  pulses with out_valid when RET finds the RAS empty.
- ras_empty  output  1  RAS count == 0 (current state).
- ras_full  output  1  RAS count == RAS_DEPTH (current state).
- ras_overflow  output  1  sticky; set on a push while full, cleared only by reset.

Behaviour:
- Reset (synchronous, active-high; priority over everything):
  - All outputs go to 0 except ras_empty, which goes to 1.
  - RAS count and top pointer go to 0.
  - A request presented in the reset cycle is dropped.
- Latency: a request accepted at edge N (in_valid=1, reset=0) drives target, link_addr, out_valid and ras_miss after edge N.
  - out_valid=1 for exactly one cycle per request.
  - Back-to-back requests give back-to-back pulses.
  - With in_valid=0: out_valid=0, ras_miss=0; target and link_addr hold their last values.
- Target arithmetic (all modulo 2^ADDR_W):
  - J/JAL: target = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00}.
  - JR: target = reg_target.
  - BR: target = pc_plus4 + (sign-extend(instr[15:0]) to ADDR_W, shifted left by 2); carry-out discarded, wraps.
  - NONE: target = pc_plus4; out_valid still pulses.
- link_addr = pc_plus4 for JAL (no delay slot); 0 for every other mode.
- RAS: circular buffer of RAS_DEPTH entries, top pointer plus count.
  - JAL push, not full: write pc_plus4 at top+1, count+1.
  - JAL push, full: overwrite the oldest entry (pointer wraps), count stays RAS_DEPTH, ras_overflow←1.
  - RET, not empty: target = top entry, pointer−1 (wraps), count−1, ras_miss=0.
  - RET, empty: target = reg_target, ras_miss=1, state unchanged.
  - Only JAL and RET touch the RAS; no mode both pushes and pops, so no same-cycle push/pop case exists.
- ras_empty/ras_full reflect state after the last edge; they update in the same cycle as out_valid for the causing request.

Test Plan:
- J: mode=001, pc_plus4=0x40001000, instr=0x08000010 → next cycle target=0x40000040, link_addr=0, out_valid=1 for one cycle.
- BR backward/wrap:
  - pc_plus4=0x00400010, instr[15:0]=0xFFFC → target=0x00400000.
  - pc_plus4=0x00000004, imm=0xFFFE → target=0xFFFFFFFC.
- JAL then RET: JAL pc_plus4=0x00400008, instr=0x0C100040 → target=0x00400100, link_addr=0x00400008, ras_empty=0; then RET with reg_target=0xDEAD0000 → target=0x00400008, ras_miss=0, ras_empty=1.
- Overflow/miss (RAS_DEPTH=4):
  - Five JALs with pc_plus4=0x10,0x20,0x30,0x40,0x50 → ras_full=1, ras_overflow=1.
  - Five RETs with reg_target=0x99 → targets 0x50,0x40,0x30,0x20, then 0x99 with ras_miss=1.
  - ras_overflow stays 1 throughout.
- Reset mid-operation: two JALs, then reset=1 with in_valid=1 mode=RET → next cycle out_valid=0, ras_empty=1, ras_overflow=0; subsequent RET with reg_target=0x1234 → target=0x1234, ras_miss=1.
- Idle hold: after the JR request (reg_target=0xABCD0000), in_valid=0 for 3 cycles → target stays 0xABCD0000, out_valid=0 each cycle.
